// File: rtl/pcie_g3_tx_block_encoder_pkg.sv
// pcie_g3_encoder_pkg: shared types, sync headers, Gen3 LFSR constants and lane seed table.
// No ports; imported by the interface users, the scrambler and the encoder top.
package pcie_g3_encoder_pkg;
  typedef enum logic [1:0] {BT_OS = 2'b01, BT_DATA = 2'b10} blk_type_e;
  typedef enum logic [1:0] {OS_NORMAL = 2'd0, OS_SKP = 2'd1, OS_EIEOS = 2'd2} os_kind_e;
  typedef enum logic {EXPECT_SOB, IN_BLOCK} frame_state_e;
  localparam logic [1:0] SH_DATA = 2'b10;
  localparam logic [1:0] SH_OS = 2'b01;
  localparam int LFSR_W = 23;
  // Taps below x^23 of x^23+x^21+x^16+x^8+x^5+x^2+1.
  localparam logic [LFSR_W-1:0] LFSR_POLY = 23'h210125;
  localparam logic [LFSR_W-1:0] LANE_SEED [8] = '{
    23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
    23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807
  };
  // One Galois step: shift up, fold the bit leaving lfsr[22] back into the taps.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], 1'b0} ^ (s[LFSR_W-1] ? LFSR_POLY : '0);
  endfunction
endpackage

// File: rtl/pcie_g3_tx_block_encoder_if.sv
// pcie_g3_tx_block_encoder_if: word stream in, encoded stream out, framing error pulse.
// master = upstream source / downstream sink side, slave = the encoder.
interface pcie_g3_tx_block_encoder_if;
  logic in_valid, in_ready, in_sob;
  logic [31:0] in_data;
  logic [1:0] in_type, in_os_kind;
  logic out_valid, out_ready, out_sob, frame_err;
  logic [31:0] out_data;
  logic [1:0] out_sh;
  modport master (
    output in_valid, in_data, in_sob, in_type, in_os_kind, out_ready,
    input in_ready, out_valid, out_data, out_sob, out_sh, frame_err
  );
  modport slave (
    input in_valid, in_data, in_sob, in_type, in_os_kind, out_ready,
    output in_ready, out_valid, out_data, out_sob, out_sh, frame_err
  );
endinterface

// File: rtl/pcie_g3_tx_block_encoder_scrambler.sv
// pcie_g3_scrambler: combinational 32-bit Gen3 scrambler, 32 unrolled LFSR steps.
// data_i/lfsr_i/seed_i in; en_i advances, bypass_i skips XOR, reload_i loads seed_i;
// data_o is the (possibly) scrambled word, lfsr_o the next LFSR state.
module pcie_g3_scrambler
  import pcie_g3_encoder_pkg::*;
(
  input  logic [31:0]       data_i,
  input  logic [LFSR_W-1:0] lfsr_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              en_i,
  input  logic              bypass_i,
  input  logic              reload_i,
  output logic [31:0]       data_o,
  output logic [LFSR_W-1:0] lfsr_o
);
  logic [LFSR_W-1:0] s;
  // Bit i of the word is bit (i%8) of byte (i/8): LSB-first, byte 0 first.
  always_comb begin
    s = lfsr_i;
    data_o = data_i;
    for (int i = 0; i < 32; i++) begin
      data_o[i] = data_i[i] ^ (s[LFSR_W-1] & ~bypass_i);
      s = lfsr_step(s);
    end
    lfsr_o = reload_i ? seed_i : en_i ? s : lfsr_i;
  end
endmodule

// File: rtl/pcie_g3_tx_block_encoder.sv
// pcie_g3_tx_block_encoder: per-lane PCIe Gen3 128b/130b block framer and scrambler.
// Ports: clk, rst_n (sync, active-low), bus (slave): in_* word stream with in_sob/type/kind,
// out_* registered encoded stream with out_sob/out_sh, frame_err one-cycle pulse.
module pcie_g3_tx_block_encoder
  import pcie_g3_encoder_pkg::*;
#(
  parameter int LANE = 0
) (
  input logic clk,
  input logic rst_n,
  pcie_g3_tx_block_encoder_if.slave bus
);
  localparam logic [LFSR_W-1:0] SEED = LANE_SEED[LANE[2:0]];
  frame_state_e state_q, state_d;
  blk_type_e type_q, type_d, cur_type;
  logic [1:0] kind_q, kind_d, cur_kind, cnt_q, cnt_d, idx;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [31:0] out_data_q, scr_data;
  logic [1:0] out_sh_q;
  logic out_valid_q, out_sob_q, frame_err_q;
  logic acc, emit, viol, last, is_data, adv, reload;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign bus.out_sob = out_sob_q;
  assign bus.out_sh = out_sh_q;
  assign bus.frame_err = frame_err_q;

  // A sob word takes its type/kind from the inputs; later words use the latched block attributes.
  // Unknown in_type values fall back to ordered set.
  always_comb begin
    acc = bus.in_valid && bus.in_ready;
    cur_type = bus.in_sob ? (bus.in_type == BT_DATA ? BT_DATA : BT_OS) : type_q;
    cur_kind = bus.in_sob ? bus.in_os_kind : kind_q;
    idx = bus.in_sob ? 2'd0 : cnt_q;
    last = idx == 2'd3;
    is_data = cur_type == BT_DATA;
    emit = acc && (bus.in_sob || state_q == IN_BLOCK);
    viol = acc && (bus.in_sob ? (state_q == IN_BLOCK || (bus.in_type != BT_DATA && bus.in_type != BT_OS))
                              : state_q == EXPECT_SOB);
    adv = emit && (is_data || (cur_kind != OS_SKP && cur_kind != OS_EIEOS));
    reload = emit && !is_data && cur_kind == OS_EIEOS && last;
  end

  always_comb begin
    state_d = emit ? (last ? EXPECT_SOB : IN_BLOCK) : state_q;
    cnt_d = emit ? idx + 2'd1 : cnt_q;
    type_d = emit ? cur_type : type_q;
    kind_d = emit ? cur_kind : kind_q;
  end

  pcie_g3_scrambler u_scr (
    .data_i  (bus.in_data),
    .lfsr_i  (lfsr_q),
    .seed_i  (SEED),
    .en_i    (adv),
    .bypass_i(!is_data),
    .reload_i(reload),
    .data_o  (scr_data),
    .lfsr_o  (lfsr_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EXPECT_SOB;
      type_q <= BT_DATA;
      kind_q <= '0;
      cnt_q <= '0;
      lfsr_q <= SEED;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sob_q <= 1'b0;
      out_sh_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q <= type_d;
      kind_q <= kind_d;
      cnt_q <= cnt_d;
      lfsr_q <= lfsr_d;
      out_valid_q <= emit || (out_valid_q && !bus.out_ready);
      frame_err_q <= viol;
      if (emit) begin
        out_data_q <= scr_data;
        out_sob_q <= bus.in_sob;
        out_sh_q <= is_data ? SH_DATA : SH_OS;
      end
    end
  end
endmodule

// File: tb/tb_pcie_g3_tx_block_encoder.sv
// tb_pcie_g3_tx_block_encoder: directed plus randomized checks against a block-level reference model.
module tb_pcie_g3_tx_block_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcie_g3_tx_block_encoder_if bus();
  pcie_g3_tx_block_encoder #(.LANE(0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  localparam logic [22:0] SEED0 = 23'h1DBFBC;
  typedef struct packed {logic [31:0] d; logic sob; logic [1:0] sh;} ow_t;

  int vectors = 0;
  int miscompares = 0;
  ow_t exp_q[$];
  ow_t snap, mon_e;
  logic [22:0] m_lfsr;
  logic [1:0] m_kind;
  bit m_in_blk, m_data, ferr_exp, stall_en, prev_stall;
  int m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Multiply by x modulo the full scrambler polynomial.
  function automatic logic [22:0] mul_x(input logic [22:0] s);
    logic [23:0] v;
    v = {s, 1'b0};
    if (v[23]) v = v ^ 24'hA10125;
    return v[22:0];
  endfunction

  // Keystream word number idx counted from the lane-0 seed.
  function automatic logic [31:0] ks_word(input int idx);
    logic [22:0] s;
    logic [31:0] k;
    s = SEED0;
    for (int i = 0; i < 32 * idx; i++) s = mul_x(s);
    for (int i = 0; i < 32; i++) begin
      k[i] = s[22];
      s = mul_x(s);
    end
    return k;
  endfunction

  function automatic logic [31:0] next_key();
    logic [31:0] k;
    for (int i = 0; i < 32; i++) begin
      k[i] = m_lfsr[22];
      m_lfsr = mul_x(m_lfsr);
    end
    return k;
  endfunction

  task automatic model_reset();
    m_lfsr = SEED0;
    m_in_blk = 0;
    m_cnt = 0;
    m_data = 0;
    m_kind = 0;
    exp_q.delete();
    ferr_exp = 0;
  endtask

  task automatic model_word(input logic [31:0] d, input logic sob, input logic [1:0] t, input logic [1:0] k);
    ow_t w;
    bit v;
    v = 0;
    if (!sob && !m_in_blk) begin
      ferr_exp = 1;
      return;
    end
    if (sob) begin
      v = m_in_blk || !(t == 2'b10 || t == 2'b01);
      m_data = t == 2'b10;
      m_kind = k;
      m_cnt = 0;
      m_in_blk = 1;
    end
    w.d = d;
    if (m_data) w.d = d ^ next_key();
    else if (m_kind == 2'd2) begin
      if (m_cnt == 3) m_lfsr = SEED0;
    end else if (m_kind != 2'd1) void'(next_key());
    w.sob = sob;
    w.sh = m_data ? 2'b10 : 2'b01;
    exp_q.push_back(w);
    m_cnt++;
    if (m_cnt == 4) m_in_blk = 0;
    ferr_exp = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the word was accepted.
  task automatic send_word(input logic [31:0] d, input logic sob, input logic [1:0] t, input logic [1:0] k);
    bit done;
    int n;
    done = 0;
    n = 0;
    bus.in_valid = 1;
    bus.in_data = d;
    bus.in_sob = sob;
    bus.in_type = t;
    bus.in_os_kind = k;
    while (!done) begin
      @(negedge clk);
      #2;
      if (bus.in_ready) begin
        done = 1;
        model_word(d, sob, t, k);
      end
      tick();
      n++;
      if (!done && n > 200) begin
        vectors++;
        miscompares++;
        $error("FAIL in_ready_timeout observed=0 expected=1");
        done = 1;
      end
    end
    bus.in_valid = 0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 0;
    repeat (n) tick();
  endtask

  task automatic drain();
    stall_en = 0;
    bus.in_valid = 0;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.out_valid); i++) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Sends a block's first word and checks its output directly one cycle later.
  task automatic first_chk(input string tag, input logic [1:0] t, input logic [1:0] k,
                           input logic [31:0] d, input logic [31:0] exp_d, input logic [1:0] exp_sh);
    send_word(d, 1, t, k);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_data"}, 64'(bus.out_data), 64'(exp_d));
    chk({tag, "_sh"}, 64'(bus.out_sh), 64'(exp_sh));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      chk("frame_err", 64'(bus.frame_err), 64'(ferr_exp));
      ferr_exp = 0;
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_hold", 64'({bus.out_data, bus.out_sob, bus.out_sh}), 64'(snap));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $error("FAIL spurious_out observed=%0h expected=none", bus.out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_word", 64'({bus.out_data, bus.out_sob, bus.out_sh}), 64'(mon_e));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      snap = {bus.out_data, bus.out_sob, bus.out_sh};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] t, k;
    int n;
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.in_sob = 0;
    bus.in_type = 0;
    bus.in_os_kind = 0;
    bus.out_ready = 1;
    stall_en = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_sob", 64'(bus.out_sob), 64'd0);
    chk("rst_out_sh", 64'(bus.out_sh), 64'd0);
    chk("rst_frame_err", 64'(bus.frame_err), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1;
    // Zero data block: keystream words 0..3 from the seed, latency 1.
    first_chk("zero_blk", 2'b10, 2'd0, 32'h0, ks_word(0), 2'b10);
    for (int i = 1; i < 4; i++) send_word(32'h0, 0, 2'b10, 2'd0);
    // Normal OS passes through but consumes keystream words 4..7.
    first_chk("os_pass", 2'b01, 2'd0, 32'h1E1E1E1E, 32'h1E1E1E1E, 2'b01);
    for (int i = 1; i < 4; i++) send_word(32'h1E1E1E1E, 0, 2'b01, 2'd0);
    first_chk("os_adv128", 2'b10, 2'd0, 32'h0, ks_word(8), 2'b10);
    for (int i = 1; i < 4; i++) send_word(32'h0, 0, 2'b10, 2'd0);
    // SKP does not advance: next data block continues at word 12.
    for (int i = 0; i < 4; i++) send_word(32'hAAAAAAAA, i == 0, 2'b01, 2'd1);
    first_chk("skp_noadv", 2'b10, 2'd0, 32'h0, ks_word(12), 2'b10);
    for (int i = 1; i < 4; i++) send_word(32'h0, 0, 2'b10, 2'd0);
    // EIEOS reseeds: following zero block matches the first one after reset.
    for (int i = 0; i < 4; i++) send_word(32'h00FF00FF, i == 0, 2'b01, 2'd2);
    first_chk("eieos_reseed", 2'b10, 2'd0, 32'h0, ks_word(0), 2'b10);
    for (int i = 1; i < 4; i++) send_word(32'h0, 0, 2'b10, 2'd0);
    drain();
    // Framing violations: early sob, stray non-sob word, illegal type.
    send_word(32'h11111111, 1, 2'b10, 2'd0);
    send_word(32'h22222222, 0, 2'b10, 2'd0);
    send_word(32'h33333333, 1, 2'b10, 2'd0);
    for (int i = 1; i < 4; i++) send_word(32'h44444444 + i, 0, 2'b10, 2'd0);
    send_word(32'hDEADBEEF, 0, 2'b10, 2'd0);
    for (int i = 0; i < 4; i++) send_word(32'h5A5A5A5A, i == 0, 2'b00, 2'd0);
    drain();
    // Random traffic with 50% output backpressure.
    stall_en = 1;
    for (int b = 0; b < 40; b++) begin
      n = $urandom_range(0, 9);
      t = n < 5 ? 2'b10 : n < 9 ? 2'b01 : 2'($urandom_range(0, 3));
      k = 2'($urandom_range(0, 3));
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 4;
      for (int w = 0; w < n; w++) send_word($urandom, w == 0, t, k);
      if ($urandom_range(0, 9) == 0) send_word($urandom, 0, 2'b10, 2'd0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();
    // Reset while a block is in flight.
    send_word(32'h0, 1, 2'b10, 2'd0);
    send_word(32'h0, 0, 2'b10, 2'd0);
    send_word(32'h0, 0, 2'b10, 2'd0);
    rst_n = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_sob", 64'(bus.out_sob), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    first_chk("midrst_reseed", 2'b10, 2'd0, 32'h0, ks_word(0), 2'b10);
    for (int i = 1; i < 4; i++) send_word(32'h0, 0, 2'b10, 2'd0);
    drain();
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
